// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: NOP encoding, opcode values, field slices
// and the per-cycle action of the IF/ID register.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ifid_op_e;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    logic r;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: r = 1'b0;
      default:                  r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    logic r;
    case (opcode)
      OP_R, OP_S, OP_SB: r = 1'b1;
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the instruction held in IF/ID reads a
// register that the load currently in ID/EX has not yet produced.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [31:0] instruction_store,
  input  logic        valid_store,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_rd,
  output logic        hazard
);

  logic [6:0] w_opcode;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_rs1_hit;
  logic       w_rs2_hit;
  logic       w_unused_bits;

  assign w_opcode      = instruction_store[OPC_MSB:OPC_LSB];
  assign w_rs1         = instruction_store[RS1_MSB:RS1_LSB];
  assign w_rs2         = instruction_store[RS2_MSB:RS2_LSB];
  assign w_unused_bits = ^{instruction_store[31:25], instruction_store[14:7]};

  // Source-match terms; x0 is never a real dependency.
  always_comb begin
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    if (IDEX_rd != 5'd0) begin
      w_rs1_hit = uses_rs1(w_opcode) && (IDEX_rd == w_rs1);
      w_rs2_hit = uses_rs2(w_opcode) && (IDEX_rd == w_rs2);
    end else begin
      w_rs1_hit = 1'b0;
      w_rs2_hit = 1'b0;
    end
  end

  assign hazard = valid_store & IDEX_MemRead & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use stall, branch flush and saturating
// stall/flush event counters. State advances on the falling clock edge.
module if_id_hazard #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [63:0]      PC_addr,
  input  logic [31:0]      instruction,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_rd,
  input  logic             branch_taken,
  output logic [63:0]      PC_addr_store,
  output logic [31:0]      instruction_store,
  output logic             valid_store,
  output logic             PC_write,
  output logic             ctrl_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import riscv_pkg::*;

  logic [63:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_hazard;
  ifid_op_e         w_op;

  hazard_detect u_hazard_detect (
    .instruction_store (r_instr),
    .valid_store       (r_valid),
    .IDEX_MemRead      (IDEX_MemRead),
    .IDEX_rd           (IDEX_rd),
    .hazard            (w_hazard)
  );

  // Select this cycle's action; a taken branch overrides any stall.
  always_comb begin
    w_op = ST_RUN;
    if (branch_taken) begin
      w_op = ST_FLUSH;
    end else if (w_hazard) begin
      w_op = ST_STALL;
    end else begin
      w_op = ST_RUN;
    end
  end

  // Pipeline register and event counters, updated on the falling edge.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc        <= 64'd0;
      r_instr     <= NOP_INSTR;
      r_valid     <= 1'b0;
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      case (w_op)
        ST_FLUSH: begin
          r_pc    <= PC_addr;
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
          if (r_flush_cnt != {CNT_W{1'b1}}) begin
            r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_STALL: begin
          if (r_stall_cnt != {CNT_W{1'b1}}) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          r_pc    <= PC_addr;
          r_instr <= instruction;
          r_valid <= 1'b1;
        end
        default: begin
          r_pc    <= r_pc;
          r_instr <= r_instr;
          r_valid <= r_valid;
        end
      endcase
    end
  end

  assign PC_write    = ~w_hazard | branch_taken;
  assign ctrl_bubble = w_hazard | ~r_valid | branch_taken;

  assign PC_addr_store     = r_pc;
  assign instruction_store = r_instr;
  assign valid_store       = r_valid;
  assign stall_cnt         = r_stall_cnt;
  assign flush_cnt         = r_flush_cnt;

endmodule

// File: tb/tb_if_id_hazard.sv
// Directed bench for if_id_hazard: a spec-level model checked against the DUT
// on every rising edge, plus hand-computed literal expectations.
module tb_if_id_hazard;

  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [63:0]      PC_addr = 64'd0;
  logic [31:0]      instruction = 32'd0;
  logic             IDEX_MemRead = 1'b0;
  logic [4:0]       IDEX_rd = 5'd0;
  logic             branch_taken = 1'b0;
  logic [63:0]      PC_addr_store;
  logic [31:0]      instruction_store;
  logic             valid_store;
  logic             PC_write;
  logic             ctrl_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // model state
  longint unsigned m_pc = 0;
  int unsigned     m_instr = 32'h13;
  bit              m_valid = 0;
  int              m_stall = 0;
  int              m_flush = 0;

  if_id_hazard #(.CNT_W(CNT_W)) dut (
    .clk (clk), .reset_n (reset_n), .PC_addr (PC_addr), .instruction (instruction),
    .IDEX_MemRead (IDEX_MemRead), .IDEX_rd (IDEX_rd), .branch_taken (branch_taken),
    .PC_addr_store (PC_addr_store), .instruction_store (instruction_store),
    .valid_store (valid_store), .PC_write (PC_write), .ctrl_bubble (ctrl_bubble),
    .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_haz(int unsigned ins, bit v, bit mr, int rd);
    int unsigned op  = ins % 128;
    int unsigned rs1 = (ins / 32768) % 32;
    int unsigned rs2 = (ins / 1048576) % 32;
    bit r1 = !(op == 'h37 || op == 'h17 || op == 'h6F);
    bit r2 = (op == 'h33 || op == 'h23 || op == 'h63);
    return v && mr && rd != 0 && ((r1 && rd == rs1) || (r2 && rd == rs2));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = 0; m_instr = 32'h13; m_valid = 0; m_stall = 0; m_flush = 0;
    end else if (branch_taken) begin
      m_pc = PC_addr; m_instr = 32'h13; m_valid = 0;
      if (m_flush < CNT_MAX) m_flush = m_flush + 1;
    end else if (m_haz(m_instr, m_valid, IDEX_MemRead, int'(IDEX_rd))) begin
      if (m_stall < CNT_MAX) m_stall = m_stall + 1;
    end else begin
      m_pc = PC_addr; m_instr = instruction; m_valid = 1;
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      bit h;
      h = m_haz(m_instr, m_valid, IDEX_MemRead, int'(IDEX_rd));
      chk("m_pc", PC_addr_store, m_pc);
      chk("m_instr", 64'(instruction_store), 64'(m_instr));
      chk("m_valid", 64'(valid_store), 64'(m_valid));
      chk("m_pc_write", 64'(PC_write), 64'(!h || branch_taken));
      chk("m_bubble", 64'(ctrl_bubble), 64'(h || !m_valid || branch_taken));
      chk("m_stall", 64'(stall_cnt), 64'(m_stall));
      chk("m_flush", 64'(flush_cnt), 64'(m_flush));
    end
  end

  initial begin
    // reset with a live input on the bus
    PC_addr = 64'h40; instruction = 32'h0050_0093;
    #1 reset_n = 1'b0;
    tick(); tick();
    chk("rst_pc", PC_addr_store, 64'h0);
    chk("rst_instr", 64'(instruction_store), 64'h13);
    chk("rst_valid", 64'(valid_store), 64'h0);
    chk("rst_bubble", 64'(ctrl_bubble), 64'h1);
    chk("rst_pcw", 64'(PC_write), 64'h1);
    chk("rst_cnts", 64'({stall_cnt, flush_cnt}), 64'h0);
    chk_en = 1'b1;

    // straight-line load
    reset_n = 1'b1; PC_addr = 64'h0; instruction = 32'h0050_0093;
    tick();
    chk("load_instr", 64'(instruction_store), 64'h0050_0093);
    chk("load_valid", 64'(valid_store), 64'h1);
    chk("load_pcw", 64'(PC_write), 64'h1);
    chk("load_bubble", 64'(ctrl_bubble), 64'h0);

    // load-use: add x6,x5,x7 behind a load to x5
    PC_addr = 64'h4; instruction = 32'h0072_8333;
    tick();
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd5; PC_addr = 64'h8; instruction = 32'h0010_0113;
    #1;
    chk("lu_pcw", 64'(PC_write), 64'h0);
    chk("lu_bubble", 64'(ctrl_bubble), 64'h1);
    tick();
    chk("lu_hold_instr", 64'(instruction_store), 64'h0072_8333);
    chk("lu_hold_pc", PC_addr_store, 64'h4);
    chk("lu_stall_cnt", 64'(stall_cnt), 64'h1);
    IDEX_MemRead = 1'b0;
    tick();
    chk("lu_resume", 64'(instruction_store), 64'h0010_0113);
    chk("lu_resume_pc", PC_addr_store, 64'h8);

    // no false stall: LUI with rs1-position bits = 5
    PC_addr = 64'hC; instruction = 32'h0002_83B7;
    tick();
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd5;
    #1 chk("lui_pcw", 64'(PC_write), 64'h1);
    tick();
    // rd = x0 never stalls
    IDEX_MemRead = 1'b0; PC_addr = 64'h10; instruction = 32'h0000_0333;
    tick();
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd0;
    #1 chk("x0_pcw", 64'(PC_write), 64'h1);
    tick();
    chk("x0_stall_cnt", 64'(stall_cnt), 64'h1);

    // flush beats stall
    IDEX_MemRead = 1'b0; PC_addr = 64'h14; instruction = 32'h0072_8333;
    tick();
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd5; branch_taken = 1'b1; PC_addr = 64'h18;
    #1 chk("fl_pcw", 64'(PC_write), 64'h1);
    tick();
    chk("fl_instr", 64'(instruction_store), 64'h13);
    chk("fl_valid", 64'(valid_store), 64'h0);
    chk("fl_flush_cnt", 64'(flush_cnt), 64'h1);
    chk("fl_stall_cnt", 64'(stall_cnt), 64'h1);
    branch_taken = 1'b0; IDEX_MemRead = 1'b0;
    #1 chk("fl_bubble", 64'(ctrl_bubble), 64'h1);
    tick();

    // saturation: 2^CNT_W + 3 stall cycles
    PC_addr = 64'h20; instruction = 32'h0072_8333;
    tick();
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd5;
    repeat ((1 << CNT_W) + 3) tick();
    chk("sat_stall_cnt", 64'(stall_cnt), 64'hFFFF);

    // reset mid-stall takes effect immediately
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_pc", PC_addr_store, 64'h0);
    chk("mid_rst_instr", 64'(instruction_store), 64'h13);
    chk("mid_rst_valid", 64'(valid_store), 64'h0);
    chk("mid_rst_pcw", 64'(PC_write), 64'h1);
    chk("mid_rst_bubble", 64'(ctrl_bubble), 64'h1);
    chk("mid_rst_cnts", 64'({stall_cnt, flush_cnt}), 64'h0);
    tick();
    reset_n = 1'b1; IDEX_MemRead = 1'b0; PC_addr = 64'h100; instruction = 32'h0050_0093;
    tick();
    chk("post_rst_pc", PC_addr_store, 64'h100);
    chk("post_rst_valid", 64'(valid_store), 64'h1);
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_hazard.md
# if_id_hazard

IF/ID pipeline register with integrated load-use hazard detection, stall and flush control for the 64-bit RISC-V pipeline. Sits between instruction fetch and decode. It captures PC and instruction each cycle, holds them when a load-use hazard is detected, and replaces them with a NOP when a taken branch is resolved. It drives the PC-write enable and the ID/EX bubble request consumed by the decode/ID_EX stage.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters
- NOP_INSTR, 32'h0000_0013, instruction inserted on flush and reset (addi x0,x0,0)

Ports:
- clk  input  1  pipeline clock; all state updates on falling edge, same as the other pipeline registers
- reset_n  input  1  asynchronous active-low reset
- PC_addr  input  64  PC of the fetched instruction
- instruction  input  32  fetched instruction
- IDEX_MemRead  input  1  MemRead currently held in ID/EX
- IDEX_rd  input  5  destination register currently held in ID/EX
- branch_taken  input  1  branch resolved taken; flush request
- PC_addr_store  output  64  registered PC to decode
- instruction_store  output  32  registered instruction to decode
- valid_store  output  1  registered instruction is real (not reset/flush NOP)
- PC_write  output  1  PC update enable to fetch; low during stall
- ctrl_bubble  output  1  force all ID/EX control bits to zero this cycle
- stall_cnt  output  CNT_W  saturating count of stall cycles
- flush_cnt  output  CNT_W  saturating count of flush events

## Operation
- Decode fields from instruction_store: opcode [6:0], rs1 [19:15], rs2 [24:20].
- uses_rs1: opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
- uses_rs2: opcode in {0110011 R, 0100011 S, 1100011 SB}.
- hazard = valid_store & IDEX_MemRead & (IDEX_rd != 0) & ((uses_rs1 & IDEX_rd==rs1) | (uses_rs2 & IDEX_rd==rs2)).
- PC_write = ~hazard | branch_taken (combinational).
- ctrl_bubble = hazard | ~valid_store | branch_taken (combinational).
- Per falling edge, priority order:
  - branch_taken: instruction_store <= NOP_INSTR, valid_store <= 0, PC_addr_store <= PC_addr; flush_cnt += 1 (saturating).
  - else hazard: hold all three registers; stall_cnt += 1 (saturating).
  - else: load PC_addr, instruction, valid_store <= 1.
- Counters saturate at all-ones, never wrap.
- Effective state machine: RUN (load), STALL (hold, one cycle per hazard; re-evaluated each cycle since ID/EX becomes a bubble), FLUSH (one cycle, then RUN).

## Timing
- Reset (reset_n low, asynchronous, immediate): PC_addr_store 0, instruction_store NOP_INSTR, valid_store 0, stall_cnt 0, flush_cnt 0. Hence PC_write 1, ctrl_bubble 1.
- Latency: input to *_store is one falling edge.
- Load-use stall lasts exactly one cycle: the bubble clears IDEX_MemRead on the same edge, so hazard drops.
- branch_taken and hazard together: flush wins, only flush_cnt increments, PC_write 1.
- rd = x0 never stalls.
- Reset asserted mid-stall or mid-flush: state returns to reset values immediately; first edge after deassert performs a normal load.
- Combinational outputs settle within the cycle from *_store and ID/EX inputs; no combinational path from instruction input to PC_write.

## Structure
- Shared package riscv_pkg: NOP_INSTR constant, opcode localparams (OP_R, OP_S, OP_SB, OP_LUI, OP_AUIPC, OP_JAL), field slice constants.
- Sub-module hazard_detect: combinational, inputs instruction_store, valid_store, IDEX_MemRead, IDEX_rd; output hazard. Register and counters stay in top.

## Test plan
- Reset: hold reset_n low with PC_addr=0x40 -> PC_addr_store 0, instruction_store 0x00000013, valid_store 0, ctrl_bubble 1, counters 0.
- Straight-line: feed addi x1,x0,5 (0x00500093) at PC 0x0 -> next falling edge instruction_store 0x00500093, valid_store 1, PC_write 1, ctrl_bubble 0.
- Load-use: IDEX_MemRead=1, IDEX_rd=5, instruction_store add x6,x5,x7 -> PC_write 0, ctrl_bubble 1, registers held one edge, stall_cnt=1; after IDEX_MemRead drops, load resumes.
- No false stall: IDEX_rd=5 with LUI x5 in IF/ID, and IDEX_rd=0 with add x6,x0,x0 -> PC_write 1, stall_cnt unchanged.
- Flush vs stall: branch_taken=1 while hazard true -> instruction_store NOP, valid_store 0, flush_cnt +1, stall_cnt unchanged.
- Saturation/reset: force 2^CNT_W+3 stalls -> stall_cnt stays 0xFFFF; drop reset_n mid-stall -> all outputs at reset values immediately.
